// File: rtl/wb_pkg.sv
// Shared types for the writeback-to-ROB path: the result bundle carried from
// the M/WB and EX/WB registers, and the arbitration source encoding.
package wb_pkg;

  localparam int WORD_SIZE       = 32;
  localparam int INSTR_TYPE_SZ   = 3;
  localparam int ROB_ENTRY_WIDTH = 5;

  typedef struct packed {
    logic [ROB_ENTRY_WIDTH-1:0] rob_id;
    logic [WORD_SIZE-1:0]       pc;
    logic                       exception;
    logic [WORD_SIZE-1:0]       virtual_addr_exception;
    logic [WORD_SIZE-1:0]       data;
    logic [INSTR_TYPE_SZ-1:0]   instruction_type;
  } wb_entry_t;

  typedef enum logic {
    SRC_MEM = 1'b0,
    SRC_ALU = 1'b1
  } src_e;

endpackage

// File: rtl/wb_rob_writer_if.sv
// Result-bundle inputs, per-source stalls and the ROB write port of the
// writeback writer. The pipeline/ROB side uses master, the writer uses slave.
interface wb_rob_writer_if;
  import wb_pkg::*;

  logic                       mem_valid;
  logic [ROB_ENTRY_WIDTH-1:0] mem_rob_id;
  logic [WORD_SIZE-1:0]       mem_pc;
  logic                       mem_exception;
  logic [WORD_SIZE-1:0]       mem_virtual_addr_exception;
  logic [WORD_SIZE-1:0]       mem_load_data;
  logic [INSTR_TYPE_SZ-1:0]   mem_instruction_type;

  logic                       alu_valid;
  logic [ROB_ENTRY_WIDTH-1:0] alu_rob_id;
  logic [WORD_SIZE-1:0]       alu_pc;
  logic                       alu_exception;
  logic [WORD_SIZE-1:0]       alu_virtual_addr_exception;
  logic [WORD_SIZE-1:0]       alu_result;
  logic [INSTR_TYPE_SZ-1:0]   alu_instruction_type;

  logic                       mem_stall;
  logic                       alu_stall;

  logic                       rob_wr_valid;
  logic [ROB_ENTRY_WIDTH-1:0] rob_wr_rob_id;
  logic [WORD_SIZE-1:0]       rob_wr_pc;
  logic                       rob_wr_exception;
  logic [WORD_SIZE-1:0]       rob_wr_virtual_addr_exception;
  logic [WORD_SIZE-1:0]       rob_wr_data;
  logic [INSTR_TYPE_SZ-1:0]   rob_wr_instruction_type;
  logic                       rob_wr_ready;

  modport master (
    output mem_valid, mem_rob_id, mem_pc, mem_exception, mem_virtual_addr_exception,
           mem_load_data, mem_instruction_type,
    output alu_valid, alu_rob_id, alu_pc, alu_exception, alu_virtual_addr_exception,
           alu_result, alu_instruction_type,
    output rob_wr_ready,
    input  mem_stall, alu_stall,
    input  rob_wr_valid, rob_wr_rob_id, rob_wr_pc, rob_wr_exception,
           rob_wr_virtual_addr_exception, rob_wr_data, rob_wr_instruction_type
  );

  modport slave (
    input  mem_valid, mem_rob_id, mem_pc, mem_exception, mem_virtual_addr_exception,
           mem_load_data, mem_instruction_type,
    input  alu_valid, alu_rob_id, alu_pc, alu_exception, alu_virtual_addr_exception,
           alu_result, alu_instruction_type,
    input  rob_wr_ready,
    output mem_stall, alu_stall,
    output rob_wr_valid, rob_wr_rob_id, rob_wr_pc, rob_wr_exception,
           rob_wr_virtual_addr_exception, rob_wr_data, rob_wr_instruction_type
  );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry FIFO of result bundles. A push into a full FIFO is ignored; the
// head is always the oldest entry written before the current edge.
module wb_fifo2
  import wb_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t dout,
  output logic      head_valid,
  output logic      full
);

  wb_entry_t  mem_q [2];
  wb_entry_t  mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign head_valid = (count_q != 2'd0);
  assign full       = (count_q == 2'd2);
  assign dout       = mem_q[rd_ptr_q];
  assign do_push    = push && !full;
  assign do_pop     = pop && head_valid;

  always_comb begin
    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone says which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_rob_writer.sv
// Buffers M/WB and EX/WB result bundles in per-source FIFOs and arbitrates
// them round-robin onto a registered ROB write port with valid/ready.
module wb_rob_writer
  import wb_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  wb_rob_writer_if.slave  bus,
  output logic            overflow_err
);

  logic      fifo_reset;
  wb_entry_t mem_in, alu_in, mem_head, alu_head;
  logic      mem_head_valid, alu_head_valid;
  logic      mem_full, alu_full;
  logic      mem_pop, alu_pop, may_load;

  wb_entry_t out_q, out_d;
  logic      out_valid_q, out_valid_d;
  src_e      prio_q, prio_d;
  logic      overflow_q, overflow_d;

  assign fifo_reset = reset || flush;

  assign mem_in = '{rob_id: bus.mem_rob_id, pc: bus.mem_pc, exception: bus.mem_exception,
                    virtual_addr_exception: bus.mem_virtual_addr_exception,
                    data: bus.mem_load_data, instruction_type: bus.mem_instruction_type};
  assign alu_in = '{rob_id: bus.alu_rob_id, pc: bus.alu_pc, exception: bus.alu_exception,
                    virtual_addr_exception: bus.alu_virtual_addr_exception,
                    data: bus.alu_result, instruction_type: bus.alu_instruction_type};

  wb_fifo2 u_mem_fifo (
    .clk(clk), .reset(fifo_reset), .push(bus.mem_valid), .pop(mem_pop), .din(mem_in),
    .dout(mem_head), .head_valid(mem_head_valid), .full(mem_full)
  );

  wb_fifo2 u_alu_fifo (
    .clk(clk), .reset(fifo_reset), .push(bus.alu_valid), .pop(alu_pop), .din(alu_in),
    .dout(alu_head), .head_valid(alu_head_valid), .full(alu_full)
  );

  // The output register may reload when empty or when the ROB takes it this edge.
  assign may_load = !out_valid_q || bus.rob_wr_ready;
  assign mem_pop  = may_load && mem_head_valid && (!alu_head_valid || prio_q == SRC_MEM);
  assign alu_pop  = may_load && alu_head_valid && (!mem_head_valid || prio_q == SRC_ALU);

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    prio_d      = prio_q;
    overflow_d  = overflow_q;
    if (flush) begin
      // Data fields are left as-is; only the valid flag matters to the ROB.
      out_valid_d = 1'b0;
      prio_d      = SRC_MEM;
    end else begin
      if ((bus.mem_valid && mem_full) || (bus.alu_valid && alu_full)) overflow_d = 1'b1;
      if (may_load) begin
        out_valid_d = mem_pop || alu_pop;
        if (mem_pop)      out_d = mem_head;
        else if (alu_pop) out_d = alu_head;
        if (mem_head_valid && alu_head_valid) prio_d = mem_pop ? SRC_ALU : SRC_MEM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      prio_q      <= SRC_MEM;
      overflow_q  <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      prio_q      <= prio_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.mem_stall                     = mem_full;
  assign bus.alu_stall                     = alu_full;
  assign bus.rob_wr_valid                  = out_valid_q;
  assign bus.rob_wr_rob_id                 = out_q.rob_id;
  assign bus.rob_wr_pc                     = out_q.pc;
  assign bus.rob_wr_exception              = out_q.exception;
  assign bus.rob_wr_virtual_addr_exception = out_q.virtual_addr_exception;
  assign bus.rob_wr_data                   = out_q.data;
  assign bus.rob_wr_instruction_type       = out_q.instruction_type;
  assign overflow_err                      = overflow_q;

endmodule
